sha256_block_sequencer: RTL and testbench
=========================================

SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  master clock; rst  in  1  synchronous, active-high reset; clock clk.
REQ-002 SHALL have ports: start  in  1  one-cycle request to hash a message; num_blocks  in  4  count of 512-bit blocks, sampled on start.
REQ-003 SHALL have ports: in_word  in  32  message word; in_valid  in  1  word present; in_ready  out  1  word accepted when in_valid&in_ready.
REQ-004 SHALL have ports: core_cmd  out  3  core command; core_cmd_w  out  1  command strobe; core_text  out  32  word to core; core_text_we  out  1  word strobe; core_busy  in  1  core computing; core_text_o  in  32  digest word from core.
REQ-005 SHALL have ports: out_word  out  32  digest word; out_valid  out  1; out_ready  in  1; out_last  out  1  marks word 7; busy  out  1  sequencer not IDLE; done  out  1  one-cycle completion pulse; err  out  1  one-cycle bad-request pulse.
REQ-006 SHALL use core command codes: 3'b010 first block (reload IV), 3'b110 continuation block, 3'b001 digest read.

Function
REQ-007 SHALL implement states IDLE, CMD, LOAD, GUARD, WAIT, READ, OUT.
REQ-008 IDLE: start with num_blocks!=0 SHALL latch num_blocks into block counter, clear word and block index, go CMD; start with num_blocks==0 SHALL pulse err next cycle and stay IDLE.
REQ-009 start while not IDLE SHALL be ignored, no err.
REQ-010 CMD: SHALL assert core_cmd_w for exactly one cycle with core_cmd=3'b010 when block index==0, else 3'b110, then go LOAD.
REQ-011 LOAD: in_ready SHALL be 1 only in LOAD; each accepted word SHALL drive core_text=in_word and core_text_we=1 in the same cycle; the 4-bit word counter increments per accepted word.
REQ-012 LOAD: in_valid gaps SHALL stall without skipping; after the 16th accepted word (counter 15 -> wrap to 0) go GUARD.
REQ-013 GUARD: SHALL last exactly one cycle, ignoring core_busy, then go WAIT.
REQ-014 WAIT: on core_busy==0 SHALL increment block index; if block index+1 < latched num_blocks go CMD, else go READ.
REQ-015 READ: SHALL strobe core_cmd_w one cycle with 3'b001, then capture core_text_o on the next 8 consecutive cycles into digest registers 0..7, then go OUT.
REQ-016 OUT: SHALL present digest words 0..7 in order with out_valid=1; advance only on out_valid&out_ready; out_last=1 with word 7.
REQ-017 Handshake at word 7 SHALL pulse done one cycle and return to IDLE; done and next start may not overlap (start in done cycle is accepted next cycle only if in IDLE).
REQ-018 out_valid SHALL hold and out_word SHALL stay stable while out_ready==0.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 core_cmd_w, core_text_we, done, err SHALL never be high outside their specified cycles; core_cmd and core_text SHALL be 0 when their strobes are low.
REQ-021 Total input words consumed per request SHALL be exactly 16*num_blocks.

Reset
REQ-022 rst SHALL force IDLE from any state, including mid-LOAD and mid-OUT, discarding partial words and digest.
REQ-023 During and after rst: in_ready, core_cmd_w, core_text_we, out_valid, out_last, busy, done, err = 0; core_cmd = 0; core_text = 0; out_word = 0; counters and digest registers = 0.
REQ-024 rst SHALL take priority over start in the same cycle.

Verification
REQ-025 Single block: num_blocks=1, 16 words 0x00000000..0x0000000F back-to-back, core busy 64 cycles -> one 3'b010 cmd, 16 core_text_we, one 3'b001, 8 digest words out, out_last on 8th, one done.
REQ-026 Bitcoin header: num_blocks=2 -> cmd sequence 3'b010, 3'b110, 3'b001; 32 words consumed; second cmd not issued until core_busy low.
REQ-027 Stalls: in_valid toggling every other cycle and out_ready low 3 cycles on word 4 -> no word lost/duplicated, out_word stable while stalled.
REQ-028 Bad request: num_blocks=0 -> err pulse 1 cycle, busy stays 0; start during LOAD -> ignored.
REQ-029 Reset mid-operation: rst after 7 words of block 0 -> all outputs 0 next cycle; fresh num_blocks=1 request completes normally.
REQ-030 Guard: core_busy rises 1 cycle late after last word -> sequencer waits in WAIT, does not advance early.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
// Feeds 16-word message blocks into a SHA-256 core, chains blocks, then
// reads the 8-word digest back and streams it out over a valid/ready port.
module sha256_block_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  num_blocks,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [2:0]  core_cmd,
  output logic        core_cmd_w,
  output logic [31:0] core_text,
  output logic        core_text_we,
  input  logic        core_busy,
  input  logic [31:0] core_text_o,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_GUARD = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;

  localparam logic [2:0] CMD_FIRST = 3'b010;
  localparam logic [2:0] CMD_CONT  = 3'b110;
  localparam logic [2:0] CMD_READ  = 3'b001;

  logic [2:0]       state;
  logic [3:0]       blk_cnt, blk_idx, word_idx, rd_cnt;
  logic [2:0]       out_idx;
  logic [7:0][31:0] digest;
  logic             done_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      blk_cnt  <= '0;
      blk_idx  <= '0;
      word_idx <= '0;
      rd_cnt   <= '0;
      out_idx  <= '0;
      digest   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (num_blocks != 4'd0) begin
            blk_cnt  <= num_blocks;
            blk_idx  <= '0;
            word_idx <= '0;
            state    <= S_CMD;
          end else begin
            err_q <= 1'b1;
          end
        end
        S_CMD:   state <= S_LOAD;
        S_LOAD: if (in_valid) begin
          word_idx <= word_idx + 4'd1;
          if (word_idx == 4'd15) state <= S_GUARD;
        end
        // The core may raise busy a cycle after the last word; skip that cycle.
        S_GUARD: state <= S_WAIT;
        S_WAIT: if (!core_busy) begin
          blk_idx <= blk_idx + 4'd1;
          if ({1'b0, blk_idx} + 5'd1 < {1'b0, blk_cnt}) begin
            state <= S_CMD;
          end else begin
            rd_cnt <= '0;
            state  <= S_READ;
          end
        end
        // rd_cnt 0 issues the read command; 1..8 capture digest words 0..7.
        S_READ: begin
          rd_cnt <= rd_cnt + 4'd1;
          if (rd_cnt != 4'd0) digest[rd_cnt[2:0] - 3'd1] <= core_text_o;
          if (rd_cnt == 4'd8) begin
            out_idx <= '0;
            state   <= S_OUT;
          end
        end
        S_OUT: if (out_ready) begin
          out_idx <= out_idx + 3'd1;
          if (out_idx == 3'd7) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while rst is held so nothing leaks out of a
  // state that is about to be discarded.
  always_comb begin
    in_ready     = 1'b0;
    core_cmd     = 3'b000;
    core_cmd_w   = 1'b0;
    core_text    = 32'h0;
    core_text_we = 1'b0;
    out_word     = 32'h0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_CMD: begin
          core_cmd_w = 1'b1;
          core_cmd   = (blk_idx == 4'd0) ? CMD_FIRST : CMD_CONT;
        end
        S_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            core_text_we = 1'b1;
            core_text    = in_word;
          end
        end
        S_READ: if (rd_cnt == 4'd0) begin
          core_cmd_w = 1'b1;
          core_cmd   = CMD_READ;
        end
        S_OUT: begin
          out_valid = 1'b1;
          out_word  = digest[out_idx];
          out_last  = (out_idx == 3'd7);
        end
        default: ;
      endcase
    end
  end

  assign done = done_q & ~rst;
  assign err  = err_q & ~rst;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench: behavioural core model plus per-scenario tasks with inline checks.
module tb_sha256_block_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]  num_blocks = 4'd0;
  logic [31:0] in_word = 32'h0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  core_cmd;
  logic        core_cmd_w, core_text_we;
  logic [31:0] core_text, core_text_o;
  logic        core_busy = 1'b0;
  logic [31:0] out_word;
  logic        out_valid, out_last, busy, done, err;
  logic        out_ready = 1'b0;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sha256_block_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .core_cmd(core_cmd), .core_cmd_w(core_cmd_w), .core_text(core_text),
    .core_text_we(core_text_we), .core_busy(core_busy), .core_text_o(core_text_o),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  // Core model: busy 64 cycles after the 16th word (optionally delayed),
  // digest word i = A000_0000 | i<<16 | low 16 bits of the word sum.
  int          late = 0;
  logic [6:0]  bcnt = '0;
  logic [1:0]  pend = '0;
  logic [3:0]  wcnt = '0;
  logic [31:0] sum = '0;
  logic        rda = 1'b0;
  logic [2:0]  rdp = '0;

  always @(posedge clk) begin
    if (rst) begin
      core_busy <= 1'b0; bcnt <= '0; pend <= '0; wcnt <= '0;
      sum <= '0; rda <= 1'b0; rdp <= '0;
    end else begin
      if (core_cmd_w && core_cmd == 3'b010) sum <= '0;
      if (core_text_we) begin
        sum  <= sum + core_text;
        wcnt <= wcnt + 4'd1;
        if (wcnt == 4'd15) begin
          if (late == 0) begin core_busy <= 1'b1; bcnt <= 7'd63; end
          else pend <= 2'(late);
        end
      end
      if (pend != 2'd0) begin
        pend <= pend - 2'd1;
        if (pend == 2'd1) begin core_busy <= 1'b1; bcnt <= 7'd63; end
      end
      if (core_busy) begin
        if (bcnt == 7'd0) core_busy <= 1'b0;
        else bcnt <= bcnt - 7'd1;
      end
      if (core_cmd_w && core_cmd == 3'b001) begin rda <= 1'b1; rdp <= '0; end
      else if (rda) begin
        rdp <= rdp + 3'd1;
        if (rdp == 3'd7) rda <= 1'b0;
      end
    end
  end

  assign core_text_o = rda ? (32'hA000_0000 | ({29'd0, rdp} << 16) | {16'd0, sum[15:0]}) : 32'h0;

  // Monitor
  logic [2:0] cmd_log[$];
  int we_n = 0, done_n = 0, err_n = 0, viol = 0, busy_cmd = 0;
  always @(negedge clk) begin
    if (core_cmd_w) begin
      cmd_log.push_back(core_cmd);
      if (core_busy) busy_cmd <= busy_cmd + 1;
    end
    if (core_text_we) we_n <= we_n + 1;
    if (done) done_n <= done_n + 1;
    if (err) err_n <= err_n + 1;
    if ((!core_cmd_w && core_cmd != 3'b0) || (!core_text_we && core_text != 32'h0) ||
        (out_last && !out_valid) || (in_ready && !busy) || (done && busy))
      viol <= viol + 1;
  end

  function automatic logic [31:0] expw(input int i, input logic [15:0] s);
    return 32'hA000_0000 | (32'(i) << 16) | {16'd0, s};
  endfunction

  logic [31:0] got[8];
  logic [7:0]  lastf;
  bit          stable_ok;

  task automatic do_start(input logic [3:0] nb);
    @(negedge clk); start = 1'b1; num_blocks = nb;
    @(negedge clk); start = 1'b0; num_blocks = 4'd0;
  endtask

  task automatic feed(input int n, input logic [31:0] base, input bit gap);
    int k = 0, t = 0;
    while (k < n && t < 4000) begin
      @(negedge clk); t++;
      if (gap && t[0]) in_valid = 1'b0;
      else begin
        in_valid = 1'b1; in_word = base + 32'(k);
        if (in_ready) k++;
      end
    end
    @(negedge clk); in_valid = 1'b0; in_word = 32'h0;
    if (k < n) begin
      vectors++; miscompares++;
      $display("FAIL feed_timeout: accepted %0d words, required %0d", k, n);
    end
  endtask

  task automatic collect(input int stall_at, input int stall_len);
    int n = 0, t = 0, st = 0;
    logic [31:0] prev = 32'h0;
    stable_ok = 1'b1; lastf = '0;
    while (n < 8 && t < 2000) begin
      @(negedge clk); t++;
      if (out_valid) begin
        if (n == stall_at && st > 0 && out_word !== prev) stable_ok = 1'b0;
        prev = out_word;
        if (n == stall_at && st < stall_len) begin out_ready = 1'b0; st++; end
        else begin out_ready = 1'b1; got[n] = out_word; lastf[n] = out_last; n++; end
      end else out_ready = 1'b0;
    end
    @(negedge clk); out_ready = 1'b0;
    if (n < 8) begin
      vectors++; miscompares++;
      $display("FAIL collect_timeout: received %0d words, required 8", n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, core_cmd_w, core_text_we, out_valid, out_last, busy, done, err} !== 8'h00) begin
      miscompares++; $display("FAIL reset_flags: got %b, want 00000000",
        {in_ready, core_cmd_w, core_text_we, out_valid, out_last, busy, done, err});
    end
    vectors++;
    if (core_cmd !== 3'b0 || core_text !== 32'h0 || out_word !== 32'h0) begin
      miscompares++; $display("FAIL reset_data: cmd %h text %h out %h, want 0", core_cmd, core_text, out_word);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: busy %b in_ready %b, want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_single_block;
    int c0 = cmd_log.size(), w0 = we_n, d0 = done_n;
    do_start(4'd1);
    feed(16, 32'h0, 1'b0);
    collect(8, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (cmd_log.size() - c0 != 2) begin
      miscompares++; $display("FAIL single_cmd_count: got %0d, want 2", cmd_log.size() - c0);
    end
    vectors++;
    if (cmd_log[c0] !== 3'b010 || cmd_log[c0+1] !== 3'b001) begin
      miscompares++; $display("FAIL single_cmd_seq: got %b %b, want 010 001", cmd_log[c0], cmd_log[c0+1]);
    end
    vectors++;
    if (we_n - w0 != 16) begin
      miscompares++; $display("FAIL single_we_count: got %0d, want 16", we_n - w0);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== expw(i, 16'h0078)) begin
        miscompares++; $display("FAIL single_word%0d: got %h, want %h", i, got[i], expw(i, 16'h0078));
      end
    end
    vectors++;
    if (lastf !== 8'h80) begin
      miscompares++; $display("FAIL single_last: got %b, want 10000000", lastf);
    end
    vectors++;
    if (done_n - d0 != 1) begin
      miscompares++; $display("FAIL single_done: got %0d pulses, want 1", done_n - d0);
    end
  endtask

  task automatic test_two_blocks;
    int c0 = cmd_log.size(), w0 = we_n, b0 = busy_cmd;
    do_start(4'd2);
    feed(32, 32'h0, 1'b0);
    collect(8, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (cmd_log.size() - c0 != 3 || cmd_log[c0] !== 3'b010 || cmd_log[c0+1] !== 3'b110 || cmd_log[c0+2] !== 3'b001) begin
      miscompares++; $display("FAIL two_cmd_seq: got n=%0d %b %b %b, want 3 010 110 001",
        cmd_log.size() - c0, cmd_log[c0], cmd_log[c0+1], cmd_log[c0+2]);
    end
    vectors++;
    if (we_n - w0 != 32) begin
      miscompares++; $display("FAIL two_we_count: got %0d, want 32", we_n - w0);
    end
    vectors++;
    if (busy_cmd - b0 != 0) begin
      miscompares++; $display("FAIL two_cmd_while_busy: got %0d, want 0", busy_cmd - b0);
    end
    vectors++;
    if (got[0] !== expw(0, 16'h01F0) || got[7] !== expw(7, 16'h01F0)) begin
      miscompares++; $display("FAIL two_digest: got %h %h, want %h %h", got[0], got[7], expw(0, 16'h01F0), expw(7, 16'h01F0));
    end
  endtask

  task automatic test_stalls;
    int w0 = we_n;
    do_start(4'd1);
    feed(16, 32'h100, 1'b1);
    collect(4, 3);
    repeat (3) @(negedge clk);
    vectors++;
    if (we_n - w0 != 16) begin
      miscompares++; $display("FAIL stall_we_count: got %0d, want 16", we_n - w0);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== expw(i, 16'h1078)) begin
        miscompares++; $display("FAIL stall_word%0d: got %h, want %h", i, got[i], expw(i, 16'h1078));
      end
    end
    vectors++;
    if (stable_ok !== 1'b1) begin
      miscompares++; $display("FAIL stall_stable: got %b, want 1", stable_ok);
    end
  endtask

  task automatic test_bad_request;
    int e0 = err_n, c0, w0, d0;
    @(negedge clk); start = 1'b1; num_blocks = 4'd0;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL bad_err_pulse: err %b busy %b, want 1 0", err, busy);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL bad_err_width: err %b busy %b, want 0 0", err, busy);
    end
    vectors++;
    if (err_n - e0 != 1) begin
      miscompares++; $display("FAIL bad_err_count: got %0d, want 1", err_n - e0);
    end
    e0 = err_n; c0 = cmd_log.size(); w0 = we_n; d0 = done_n;
    do_start(4'd1);
    feed(5, 32'h0, 1'b0);
    do_start(4'd3);
    feed(11, 32'h5, 1'b0);
    collect(8, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (cmd_log.size() - c0 != 2 || err_n - e0 != 0) begin
      miscompares++; $display("FAIL busy_start_ignored: cmds %0d errs %0d, want 2 0", cmd_log.size() - c0, err_n - e0);
    end
    vectors++;
    if (we_n - w0 != 16 || done_n - d0 != 1) begin
      miscompares++; $display("FAIL busy_start_words: we %0d done %0d, want 16 1", we_n - w0, done_n - d0);
    end
    vectors++;
    if (got[3] !== expw(3, 16'h0078)) begin
      miscompares++; $display("FAIL busy_start_digest: got %h, want %h", got[3], expw(3, 16'h0078));
    end
  endtask

  task automatic test_reset_mid;
    int w0, d0;
    do_start(4'd1);
    feed(7, 32'h0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ready, core_cmd_w, core_text_we, out_valid, out_last, busy, done, err} !== 8'h00 ||
        core_cmd !== 3'b0 || core_text !== 32'h0 || out_word !== 32'h0) begin
      miscompares++; $display("FAIL midreset_outputs: flags %b cmd %h text %h out %h, want all 0",
        {in_ready, core_cmd_w, core_text_we, out_valid, out_last, busy, done, err}, core_cmd, core_text, out_word);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL midreset_idle: busy %b in_ready %b, want 0 0", busy, in_ready);
    end
    w0 = we_n; d0 = done_n;
    do_start(4'd1);
    feed(16, 32'h0, 1'b0);
    collect(8, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (we_n - w0 != 16 || done_n - d0 != 1) begin
      miscompares++; $display("FAIL midreset_rerun: we %0d done %0d, want 16 1", we_n - w0, done_n - d0);
    end
    vectors++;
    if (got[7] !== expw(7, 16'h0078) || lastf !== 8'h80) begin
      miscompares++; $display("FAIL midreset_digest: got %h last %b, want %h 10000000", got[7], lastf, expw(7, 16'h0078));
    end
  endtask

  task automatic test_guard;
    int c0 = cmd_log.size(), b0 = busy_cmd;
    late = 1;
    do_start(4'd1);
    feed(16, 32'h10, 1'b0);
    collect(8, 0);
    repeat (3) @(negedge clk);
    late = 0;
    vectors++;
    if (busy_cmd - b0 != 0 || cmd_log.size() - c0 != 2) begin
      miscompares++; $display("FAIL guard_early_read: busy cmds %0d total %0d, want 0 2", busy_cmd - b0, cmd_log.size() - c0);
    end
    vectors++;
    if (got[0] !== expw(0, 16'h0178)) begin
      miscompares++; $display("FAIL guard_digest: got %h, want %h", got[0], expw(0, 16'h0178));
    end
  endtask

  task automatic test_invariants;
    vectors++;
    if (viol != 0) begin
      miscompares++; $display("FAIL strobe_invariants: got %0d violations, want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_two_blocks();
    test_stalls();
    test_bad_request();
    test_reset_mid();
    test_guard();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
